// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package mem_pkg;

  typedef enum logic [1:0] {
    DSIZE_BYTE    = 2'd0,
    DSIZE_HALF    = 2'd1,
    DSIZE_ILLEGAL = 2'd2,
    DSIZE_WORD    = 2'd3
  } dsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: byte enables, store-data placement and
// right-justified load extraction for one 32-bit memory word.
module dmem_lane_align
  import mem_pkg::*;
(
  input  dsize_e      dsize_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [4:0] sh;

  // Offset k lives at bits (3-k)*8 upward, so the shift is ~k scaled by 8.
  always_comb begin
    be_o     = 4'b0000;
    wlanes_o = '0;
    rdata_o  = '0;
    sh       = '0;
    case (dsize_i)
      DSIZE_BYTE: begin
        sh       = {~addr_lo_i, 3'b000};
        be_o     = 4'b0001 << ~addr_lo_i;
        wlanes_o = {24'b0, wdata_i[7:0]} << sh;
        rdata_o  = {24'b0, 8'(rword_i >> sh)};
      end
      DSIZE_HALF: begin
        sh       = {~addr_lo_i[1], 4'b0000};
        be_o     = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wlanes_o = {16'b0, wdata_i[15:0]} << sh;
        rdata_o  = {16'b0, 16'(rword_i >> sh)};
      end
      DSIZE_WORD: begin
        be_o     = 4'b1111;
        wlanes_o = wdata_i;
        rdata_o  = rword_i;
      end
      default: begin
        be_o     = 4'b0000;
        wlanes_o = '0;
        rdata_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with big-endian byte lanes.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned half/word requests return an error.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_dsize,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(SIZE);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          wr_q;
  dsize_e        dsize_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem_q [SIZE/4];

  logic          accept;
  logic          go_resp;
  logic          acc_wr;
  dsize_e        acc_dsize;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_err;
  logic          misalign;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   ld_data;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW];

  assign accept  = req_valid & ready_q;
  assign go_resp = (LATENCY == 1) ? accept
                                  : ((state_q == WAIT) && (cnt_q == CW'(1)));

  // With single-cycle latency the access happens on the acceptance edge,
  // before the request latch holds anything, so use the live request.
  assign acc_wr    = (LATENCY == 1) ? req_wr               : wr_q;
  assign acc_dsize = (LATENCY == 1) ? dsize_e'(req_dsize)  : dsize_q;
  assign acc_addr  = (LATENCY == 1) ? req_addr[AW-1:0]     : addr_q;
  assign acc_wdata = (LATENCY == 1) ? req_wdata            : wdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((acc_dsize == DSIZE_HALF) && acc_addr[0]) ||
                    ((acc_dsize == DSIZE_WORD) && (acc_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign acc_err = (acc_dsize == DSIZE_ILLEGAL) || misalign;
  assign rword   = mem_q[acc_addr[AW-1:2]];

  dmem_lane_align u_align (
    .dsize_i   (acc_dsize),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wlanes_o  (wlanes),
    .rdata_o   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (req_valid) begin
            if (LATENCY == 1) begin
              state_q  <= RESP;
              ready_q  <= 1'b1;
              rvalid_q <= 1'b1;
            end else begin
              state_q  <= WAIT;
              cnt_q    <= CW'(LATENCY - 1);
              ready_q  <= 1'b0;
              rvalid_q <= 1'b0;
            end
          end else begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= RESP;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
        end
      endcase
      if (go_resp) begin
        rdata_q <= (acc_wr || acc_err) ? 32'h0 : ld_data;
        err_q   <= acc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_wr;
      dsize_q <= dsize_e'(req_dsize);
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Storage is never cleared; only the enabled lanes of a store change.
  always_ff @(posedge clk) begin
    if (go_resp && acc_wr && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[acc_addr[AW-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign stall      = req_valid & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, SIZE=16384); honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

  localparam int SIZE    = 16384;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_dsize = 2'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  dmem_responder #(.SIZE(SIZE), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_dsize  (req_dsize),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, " resp_rdata"}, resp_rdata, 32'd0);
    chk({nm, " resp_err"}, 32'(resp_err), 32'd0);
    chk({nm, " stall"}, 32'(stall), 32'd0);
  endtask

  // Present one request, hold it through any stall, record the expectation.
  task automatic issue(input string nm, input logic wr, input logic [1:0] ds,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee,
                       input int exp_stall, input bit push);
    int stalls = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_dsize = ds; req_addr = a; req_wdata = wd;
    #1;
    while (!req_ready && stalls < 20) begin
      chk({nm, " stall high"}, 32'(stall), 32'd1);
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL %s accept: never ready, required ready within 20 cycles", nm);
      req_valid = 1'b0;
      return;
    end
    chk({nm, " stall low"}, 32'(stall), 32'd0);
    if (push) q.push_back('{er, ee, cyc, nm});
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk({nm, " stall cycles"}, 32'(stalls), 32'(exp_stall));
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() > 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected response: rdata %h err %b, required none", resp_rdata, resp_err);
        end else begin
          e = q.pop_front();
          chk({e.name, " rdata"}, resp_rdata, e.rdata);
          chk({e.name, " err"}, 32'(resp_err), 32'(e.err));
          chk({e.name, " latency"}, 32'(cyc - e.cyc), 32'(LATENCY));
        end
      end
    end
  end

  localparam logic [1:0] B = 2'd0, H = 2'd1, X = 2'd2, W = 2'd3;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  initial begin
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset held");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after reset");

    issue("st W 11223344@10", 1, W, 32'h10, 32'h11223344, 32'h0, 0, 0, 1);
    issue("ld W @10",         0, W, 32'h10, 32'h0, 32'h11223344, 0, 1, 1);
    issue("ld B @11",         0, B, 32'h11, 32'h0, 32'h00000022, 0, 1, 1);
    issue("ld H @12",         0, H, 32'h12, 32'h0, 32'h00003344, 0, 1, 1);
    issue("st B AB@13",       1, B, 32'h13, 32'hFFFFFFAB, 32'h0, 0, 1, 1);
    issue("ld W after byte",  0, W, 32'h10, 32'h0, 32'h112233AB, 0, 1, 1);
    issue("st dsize2 @10",    1, X, 32'h10, 32'hDEADBEEF, 32'h0, 1, 1, 1);
    issue("ld W after err",   0, W, 32'h10, 32'h0, 32'h112233AB, 0, 1, 1);
    issue("ld H @11 misal",   0, H, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h00001122, TRAP, 1, 1);
    issue("st W A5A5A5A5@14", 1, W, 32'h14, 32'hA5A5A5A5, 32'h0, 0, 1, 1);
    issue("st H BEEF@16",     1, H, 32'h16, 32'h0000BEEF, 32'h0, 0, 1, 1);
    issue("ld W @14",         0, W, 32'h14, 32'h0, 32'hA5A5BEEF, 0, 1, 1);
    issue("ld B @14",         0, B, 32'h14, 32'h0, 32'h000000A5, 0, 1, 1);
    issue("ld W @12 misal",   0, W, 32'h12, 32'h0, TRAP ? 32'h0 : 32'h112233AB, TRAP, 1, 1);
    issue("st H 1234@15 mis", 1, H, 32'h15, 32'h00001234, 32'h0, TRAP, 1, 1);
    issue("ld W @14 after",   0, W, 32'h14, 32'h0, TRAP ? 32'hA5A5BEEF : 32'h1234BEEF, 0, 1, 1);
    issue("st W restore@10",  1, W, 32'h10, 32'h11223344, 32'h0, 0, 1, 1);
    drain();

    // Reset lands in WAIT of a store: nothing commits, nothing responds.
    issue("st W FFFFFFFF rst", 1, W, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk_idle_outputs("mid-access reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("after mid reset");

    issue("ld W @10 post rst", 0, W, 32'h10, 32'h0, 32'h11223344, 0, 0, 1);
    issue("ld W @10+SIZE",     0, W, 32'h10 + SIZE, 32'h0, 32'h11223344, 0, 1, 1);
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
